fetch_queue: RTL and testbench

- Instruction fetch front end sitting directly upstream of decode/register read in the MIPS core.
- Generates sequential byte-addressed PCs and issues requests to instruction memory over a valid/ready request and in-order response interface.
- Buffers returned words with their PCs in a small FIFO and presents them to decode with a valid/ready handshake.
- Handles branch/jump redirects by flushing the FIFO and discarding responses still in flight.

---
 rtl/fetch_queue.sv | 159 +++++++++++++++
 tb/tb_fetch_queue.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch front end for the MIPS core.
//   Generates sequential word-aligned PCs and issues them to instruction memory.
//   Returned words are buffered with their PCs in a DEPTH-entry FIFO.
//   The FIFO head is presented to decode with a valid/ready handshake.
//   A redirect flushes the FIFO, restarts fetch at the target, and marks every
//   response still in flight for discard.
// Optional: define FETCH_QUEUE_PERF_EN to enable the perf_fetched / perf_flushes
//   counters. When it is undefined both ports read 0.
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   redirect_valid, redirect_pc   one-cycle redirect from branch/jump resolution
//   imem_req_valid/addr/ready     fetch request handshake
//   imem_rsp_valid/data           in-order responses, at most one per cycle
//   out_valid/pc/instr/ready      head-of-queue handshake to decode
//   perf_fetched, perf_flushes    optional performance counters
module fetch_queue #(
    parameter int          DEPTH           = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    input  logic        out_ready,
    output logic [31:0] perf_fetched,
    output logic [15:0] perf_flushes
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    logic [31:0]   fetch_pc_r;
    logic [31:0]   rsp_pc_r;
    logic [31:0]   pc_mem_r    [DEPTH];
    logic [31:0]   instr_mem_r [DEPTH];
    logic [AW-1:0] head_r;
    logic [AW-1:0] tail_r;
    logic [CW-1:0] count_r;
    logic [OW-1:0] outst_r;
    logic [OW-1:0] drop_r;

    logic [31:0]   credit_s;
    logic          req_valid_s;
    logic          accept_s;
    logic          rsp_fire_s;
    logic          push_s;
    logic          pop_s;
    logic [31:0]   redirect_target_s;
    logic [1:0]    redirect_lsb_unused_s;

    // Handshake decode.
    // A response is only meaningful while something is outstanding.
    // A FIFO slot is reserved for every outstanding request, so a push can never overflow.
    always_comb begin
        credit_s              = 32'(count_r) + 32'(outst_r);
        req_valid_s           = !reset && !redirect_valid &&
                                (credit_s < 32'(DEPTH)) &&
                                (32'(outst_r) < 32'(MAX_OUTSTANDING));
        accept_s              = req_valid_s && imem_req_ready;
        rsp_fire_s            = imem_rsp_valid && (outst_r != OW'(0));
        push_s                = rsp_fire_s && (drop_r == OW'(0)) && !redirect_valid;
        pop_s                 = (count_r != CW'(0)) && out_ready && !redirect_valid;
        redirect_target_s     = {redirect_pc[31:2], 2'b00};
        redirect_lsb_unused_s = redirect_pc[1:0];
    end

    // Fetch PC, response tagging, credit/drop accounting and FIFO storage.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_r <= RESET_PC;
            rsp_pc_r   <= RESET_PC;
            head_r     <= AW'(0);
            tail_r     <= AW'(0);
            count_r    <= CW'(0);
            outst_r    <= OW'(0);
            drop_r     <= OW'(0);
        end else if (redirect_valid) begin
            // Flush the FIFO.
            // Every request not answered this cycle becomes a response to drop.
            fetch_pc_r <= redirect_target_s;
            rsp_pc_r   <= redirect_target_s;
            head_r     <= AW'(0);
            tail_r     <= AW'(0);
            count_r    <= CW'(0);
            outst_r    <= outst_r - OW'(rsp_fire_s);
            drop_r     <= outst_r - OW'(rsp_fire_s);
        end else begin
            if (accept_s) begin
                fetch_pc_r <= fetch_pc_r + 32'd4;
            end
            outst_r <= outst_r + OW'(accept_s) - OW'(rsp_fire_s);
            if (rsp_fire_s && (drop_r != OW'(0))) begin
                drop_r <= drop_r - OW'(1);
            end
            if (push_s) begin
                pc_mem_r[tail_r]    <= rsp_pc_r;
                instr_mem_r[tail_r] <= imem_rsp_data;
                tail_r              <= tail_r + AW'(1);
                rsp_pc_r            <= rsp_pc_r + 32'd4;
            end
            if (pop_s) begin
                head_r <= head_r + AW'(1);
            end
            count_r <= count_r + CW'(push_s) - CW'(pop_s);
        end
    end

    // Output view of the registered state.
    always_comb begin
        imem_req_valid = req_valid_s;
        imem_req_addr  = fetch_pc_r;
        out_valid      = (count_r != CW'(0));
        if (count_r != CW'(0)) begin
            out_pc    = pc_mem_r[head_r];
            out_instr = instr_mem_r[head_r];
        end else begin
            out_pc    = 32'h0000_0000;
            out_instr = 32'h0000_0000;
        end
    end

`ifdef FETCH_QUEUE_PERF_EN
    logic [31:0] perf_fetched_r;
    logic [15:0] perf_flushes_r;

    // Performance counters.
    // Pops taken in a redirect cycle do not count.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched_r <= 32'h0000_0000;
            perf_flushes_r <= 16'h0000;
        end else begin
            if (pop_s) begin
                perf_fetched_r <= perf_fetched_r + 32'd1;
            end
            if (redirect_valid) begin
                perf_flushes_r <= perf_flushes_r + 16'd1;
            end
        end
    end

    assign perf_fetched = perf_fetched_r;
    assign perf_flushes = perf_flushes_r;
`else
    assign perf_fetched = 32'h0000_0000;
    assign perf_flushes = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (DEPTH=4, MAX_OUTSTANDING=2, RESET_PC=0).
// Memory model: the word at address a is {16'hC0DE, a[15:0]}.
// It returns responses in order, mem_lat cycles after acceptance, at most one per cycle.
module tb_fetch_queue;

    logic        clk;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_ready;
    logic [31:0] perf_fetched;
    logic [15:0] perf_flushes;

    int n_vec = 0;
    int n_err = 0;

    // Memory model controls.
    logic        mem_auto   = 1'b1;
    logic        mem_toggle = 1'b0;
    int          mem_lat    = 1;
    logic        ready_man  = 1'b1;
    logic        tog        = 1'b0;
    logic        auto_v     = 1'b0;
    logic [31:0] auto_d     = 32'h0;
    logic        man_v      = 1'b0;
    logic [31:0] man_d      = 32'h0;
    int          cyc        = 0;
    logic [31:0] q_addr[$];
    int          q_due[$];

    // Pops observed by decode, in order.
    logic [31:0] cap_pc[$];
    logic [31:0] cap_in[$];

    logic        prev_stall = 1'b0;
    logic [31:0] prev_addr  = 32'h0;

    assign imem_req_ready = mem_toggle ? tog : ready_man;
    assign imem_rsp_valid = mem_auto ? auto_v : man_v;
    assign imem_rsp_data  = mem_auto ? auto_d : man_d;

    fetch_queue #(.DEPTH(4), .MAX_OUTSTANDING(2), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
        .out_ready(out_ready),
        .perf_fetched(perf_fetched), .perf_flushes(perf_flushes)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic ok, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (ok !== 1'b1) begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected finish");
        $fatal(1, "timeout");
    end

    // Mid-cycle sampling: record accepted requests, captured pops, and address hold.
    always @(negedge clk) begin
        if (reset) begin
            q_addr.delete();
            q_due.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && imem_req_valid)
                chk("addr_hold", imem_req_addr === prev_addr, imem_req_addr, prev_addr);
            if (mem_auto && imem_req_valid && imem_req_ready) begin
                q_addr.push_back(imem_req_addr);
                q_due.push_back(cyc + mem_lat);
            end
            if (out_valid && out_ready && !redirect_valid) begin
                cap_pc.push_back(out_pc);
                cap_in.push_back(out_instr);
            end
            prev_stall = imem_req_valid && !imem_req_ready;
            prev_addr  = imem_req_addr;
        end
    end

    // Memory response driver, updated just after each edge.
    always @(posedge clk) begin
        #1;
        cyc++;
        tog = ~tog;
        if (q_addr.size() > 0 && q_due[0] <= cyc) begin
            auto_v = 1'b1;
            auto_d = mem_word(q_addr[0]);
            void'(q_addr.pop_front());
            void'(q_due.pop_front());
        end else begin
            auto_v = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        redirect_valid = 1'b0;
        tick();
        tick();
        cap_pc.delete();
        cap_in.delete();
    endtask

    initial begin
        int n0;
        int k;
        reset = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        out_ready = 1'b1;

        // ---- Reset state ----
        do_reset();
        #1;
        chk("rst_req_valid", imem_req_valid === 1'b0, imem_req_valid, 1'b0);
        chk("rst_out_valid", out_valid === 1'b0, out_valid, 1'b0);
        chk("rst_out_pc", out_pc === 32'h0, out_pc, 32'h0);
        chk("rst_perf_fetched", perf_fetched === 32'h0, perf_fetched, 32'h0);
        chk("rst_perf_flushes", perf_flushes === 16'h0, perf_flushes, 32'h0);

        // ---- Ideal memory, latency and streaming ----
        reset = 1'b0;
        #1;
        chk("lat_req_valid", imem_req_valid === 1'b1, imem_req_valid, 1'b1);
        chk("lat_req_addr0", imem_req_addr === 32'h0, imem_req_addr, 32'h0);
        tick();
        #1;
        chk("lat_req_addr1", imem_req_addr === 32'h4, imem_req_addr, 32'h4);
        chk("lat_rsp_cycle_out_valid", out_valid === 1'b0, out_valid, 1'b0);
        tick();
        #1;
        chk("lat_out_valid", out_valid === 1'b1, out_valid, 1'b1);
        chk("lat_out_pc0", out_pc === 32'h0, out_pc, 32'h0);
        chk("lat_out_instr0", out_instr === 32'hC0DE_0000, out_instr, 32'hC0DE_0000);
        n0 = cap_pc.size();
        for (int i = 0; i < 8; i++) tick();
        chk("steady_8_pops", (cap_pc.size() - n0) === 8, cap_pc.size() - n0, 8);

        // ---- Backpressure: fill to DEPTH then drain ----
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        #1;
        chk("full_req_valid", imem_req_valid === 1'b0, imem_req_valid, 1'b0);
        chk("full_out_valid", out_valid === 1'b1, out_valid, 1'b1);
        chk("full_head_pc", out_pc === 32'(4 * cap_pc.size()), out_pc, 32'(4 * cap_pc.size()));
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        chk("drain_count", cap_pc.size() >= 16, cap_pc.size(), 16);
        for (int i = 0; i < 16 && i < cap_pc.size(); i++) begin
            chk("stream_pc", cap_pc[i] === 32'(4 * i), cap_pc[i], 32'(4 * i));
            chk("stream_instr", cap_in[i] === {16'hC0DE, 16'(4 * i)}, cap_in[i], {16'hC0DE, 16'(4 * i)});
        end

        // ---- Redirect scenarios, manually driven memory ----
        mem_auto = 1'b0;
        ready_man = 1'b0;
        man_v = 1'b0;
        out_ready = 1'b0;
        do_reset();
        reset = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h10;
        #1;
        chk("redir_no_req", imem_req_valid === 1'b0, imem_req_valid, 1'b0);
        tick();
        redirect_valid = 1'b0;
        ready_man = 1'b1;
        #1;
        chk("redir_empty_addr", imem_req_addr === 32'h10, imem_req_addr, 32'h10);
        chk("redir_empty_valid", imem_req_valid === 1'b1, imem_req_valid, 1'b1);
        tick();
        #1;
        chk("req_addr_14", imem_req_addr === 32'h14, imem_req_addr, 32'h14);
        tick();
        ready_man = 1'b0;
        #1;
        chk("max_outstanding_block", imem_req_valid === 1'b0, imem_req_valid, 1'b0);
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        tick();
        redirect_valid = 1'b0;
        man_v = 1'b1;
        man_d = 32'hC0DE_0010;
        tick();
        man_d = 32'hC0DE_0014;
        tick();
        man_v = 1'b0;
        #1;
        chk("drop_out_valid", out_valid === 1'b0, out_valid, 1'b0);
        chk("after_drop_req_valid", imem_req_valid === 1'b1, imem_req_valid, 1'b1);
        chk("after_drop_addr", imem_req_addr === 32'h40, imem_req_addr, 32'h40);
        ready_man = 1'b1;
        tick();
        ready_man = 1'b0;
        man_v = 1'b1;
        man_d = 32'hC0DE_0040;
        tick();
        man_v = 1'b0;
        #1;
        chk("redir_out_valid", out_valid === 1'b1, out_valid, 1'b1);
        chk("redir_out_pc", out_pc === 32'h40, out_pc, 32'h40);
        chk("redir_out_instr", out_instr === 32'hC0DE_0040, out_instr, 32'hC0DE_0040);

        // Response in the redirect cycle, then a back-to-back redirect to an unaligned target.
        ready_man = 1'b1;
        tick();
        ready_man = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h80;
        man_v = 1'b1;
        man_d = 32'hC0DE_0044;
        tick();
        man_v = 1'b0;
        redirect_pc = 32'h43;
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("b2b_out_valid", out_valid === 1'b0, out_valid, 1'b0);
        chk("b2b_addr_aligned", imem_req_addr === 32'h40, imem_req_addr, 32'h40);
        ready_man = 1'b1;
        tick();
        ready_man = 1'b0;
        #1;
        chk("stall_addr", imem_req_addr === 32'h44, imem_req_addr, 32'h44);
        tick();
        #1;
        chk("stall_addr_held", imem_req_addr === 32'h44, imem_req_addr, 32'h44);
        man_v = 1'b1;
        man_d = 32'hC0DE_0040;
        tick();
        man_v = 1'b0;
        #1;
        chk("b2b_no_drop_valid", out_valid === 1'b1, out_valid, 1'b1);
        chk("b2b_out_pc", out_pc === 32'h40, out_pc, 32'h40);
        chk("b2b_out_instr", out_instr === 32'hC0DE_0040, out_instr, 32'hC0DE_0040);

        // ---- Perf counters: 8 pops, 2 redirects ----
        mem_auto = 1'b1;
        mem_lat = 1;
        ready_man = 1'b1;
        out_ready = 1'b1;
        do_reset();
        reset = 1'b0;
        k = 0;
        while (cap_pc.size() < 8 && k < 100) begin
            tick();
            k++;
        end
        out_ready = 1'b0;
        chk("perf_pop_wait", cap_pc.size() === 8, cap_pc.size(), 8);
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        tick();
        redirect_valid = 1'b0;
        tick();
        redirect_valid = 1'b1;
        tick();
        redirect_valid = 1'b0;
        #1;
`ifdef FETCH_QUEUE_PERF_EN
        chk("perf_fetched", perf_fetched === 32'd8, perf_fetched, 32'd8);
        chk("perf_flushes", perf_flushes === 16'd2, perf_flushes, 32'd2);
`else
        chk("perf_fetched_off", perf_fetched === 32'd0, perf_fetched, 32'd0);
        chk("perf_flushes_off", perf_flushes === 16'd0, perf_flushes, 32'd0);
`endif

        // ---- Toggling ready, 3-cycle latency: same stream as the ideal memory ----
        mem_lat = 3;
        mem_toggle = 1'b1;
        out_ready = 1'b1;
        do_reset();
        reset = 1'b0;
        for (int i = 0; i < 60; i++) tick();
        chk("slow_count", cap_pc.size() >= 8, cap_pc.size(), 8);
        for (int i = 0; i < 8 && i < cap_pc.size(); i++) begin
            chk("slow_pc", cap_pc[i] === 32'(4 * i), cap_pc[i], 32'(4 * i));
            chk("slow_instr", cap_in[i] === {16'hC0DE, 16'(4 * i)}, cap_in[i], {16'hC0DE, 16'(4 * i)});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
